// File: rtl/psum_scratch_buffer_if.sv
// Controller <-> partial-sum scratchpad bus.
//
// Handshake semantics (single comment for the whole bus):
//   - wen / psum_ren / psum_clear are single-cycle request strobes sampled on
//     the rising clock edge; there is no ready back-pressure, the buffer always
//     accepts or drops within that edge (drops are reported through overflow).
//   - rvalid is the only "valid" on the return path: it is high for exactly
//     one cycle after an edge that performed a read, and rdata is meaningful
//     only while rvalid is high (it holds its last value otherwise).
//   - psum_empty / psum_full / count reflect the registered occupancy and so
//     describe the state the next edge will act on.
interface psum_scratch_buffer_if #(
  parameter int SCRATCH_WIDTH = 16,
  parameter int ADDR_LEN      = 4
);
  logic                     psum_clear;
  logic                     wen;
  logic [SCRATCH_WIDTH-1:0] wdata;
  logic                     accumulate;
  logic                     psum_ren;
  logic                     psum_same_addr;
  logic [SCRATCH_WIDTH-1:0] rdata;
  logic                     rvalid;
  logic                     psum_empty;
  logic                     psum_full;
  logic                     psum_done;
  logic [ADDR_LEN:0]        count;
  logic                     overflow;

  // Controller side: drives requests, observes status and read data.
  modport master (
    output psum_clear, wen, wdata, accumulate, psum_ren, psum_same_addr,
    input  rdata, rvalid, psum_empty, psum_full, psum_done, count, overflow
  );

  // Buffer side.
  modport slave (
    input  psum_clear, wen, wdata, accumulate, psum_ren, psum_same_addr,
    output rdata, rvalid, psum_empty, psum_full, psum_done, count, overflow
  );
endinterface

// File: rtl/psum_scratch_buffer.sv
// Partial-sum scratchpad: circular FIFO of PE partial sums with in-place
// accumulation onto the newest entry, peek/pop reads and drain/overflow status.
module psum_scratch_buffer #(
  parameter int SCRATCH_DEPTH = 16,
  parameter int SCRATCH_WIDTH = 16,
  parameter int ADDR_LEN      = 4
) (
  input logic                  clk,
  input logic                  rst,
  psum_scratch_buffer_if.slave bus
);

  localparam logic [ADDR_LEN:0]   FULL_COUNT = (ADDR_LEN+1)'(SCRATCH_DEPTH);
  localparam logic [ADDR_LEN:0]   ONE_COUNT  = (ADDR_LEN+1)'(1);
  localparam logic [ADDR_LEN-1:0] PTR_ONE    = ADDR_LEN'(1);

  logic [SCRATCH_WIDTH-1:0] mem [SCRATCH_DEPTH];

  logic [ADDR_LEN-1:0]      rd_ptr;
  logic [ADDR_LEN-1:0]      wr_ptr;
  logic [ADDR_LEN-1:0]      last_ptr;
  logic [ADDR_LEN:0]        count_q;
  logic [ADDR_LEN:0]        count_next;
  logic [SCRATCH_WIDTH-1:0] rdata_q;
  logic                     rvalid_q;
  logic                     done_q;
  logic                     overflow_q;

  logic                     is_empty;
  logic                     is_full;
  logic                     is_one;
  logic                     do_read;
  logic                     do_pop;
  logic                     acc_in_place;
  logic                     push_req;
  logic                     push_ok;
  logic                     push_drop;
  logic                     drain;
  logic [SCRATCH_WIDTH-1:0] acc_sum;

  // Status is derived from the registered count only.
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_COUNT);
  assign is_one   = (count_q == ONE_COUNT);

  // Newest entry sits just behind the write pointer; wrap is free with
  // a power-of-two depth.
  assign last_ptr = wr_ptr - PTR_ONE;
  assign acc_sum  = mem[last_ptr] + bus.wdata;

  // Request decode for the current edge.
  always_comb begin
    do_read      = bus.psum_ren && !is_empty;
    do_pop       = do_read && !bus.psum_same_addr;
    // Accumulating onto the single entry that is being popped would lose the
    // sum, so that case degrades into a push of wdata.
    acc_in_place = bus.wen && bus.accumulate && !is_empty && !(is_one && do_pop);
    push_req     = bus.wen && !acc_in_place;
    // A pop in the same edge frees a slot, so a full buffer still accepts.
    push_ok      = push_req && (!is_full || do_pop);
    push_drop    = push_req && is_full && !do_pop;
    drain        = do_pop && is_one && !push_ok;
  end

  // Occupancy update: push and pop in one edge cancel out.
  always_comb begin
    count_next = count_q;
    case ({push_ok, do_pop})
      2'b10:   count_next = count_q + ONE_COUNT;
      2'b01:   count_next = count_q - ONE_COUNT;
      default: count_next = count_q;
    endcase
  end

  // Control state: async reset, then synchronous flush, then normal operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.psum_clear) begin
      // rdata keeps its last value; it is only meaningful with rvalid anyway.
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rvalid_q <= do_read;
      if (do_read) begin
        rdata_q <= mem[rd_ptr];
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (push_drop) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_next;
      done_q  <= drain;
    end
  end

  // Storage array: no reset, contents are don't-care after reset or flush.
  // A read of the same entry in this edge sees the pre-write value.
  always_ff @(posedge clk) begin
    if (!rst && !bus.psum_clear) begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.wdata;
      end else if (acc_in_place) begin
        mem[last_ptr] <= acc_sum;
      end
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.psum_done  = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.count      = count_q;
  assign bus.psum_empty = is_empty;
  assign bus.psum_full  = is_full;

endmodule

// File: tb/tb_psum_scratch_buffer.sv
// Self-checking bench for psum_scratch_buffer.
module tb_psum_scratch_buffer;

  localparam int W = 16;
  localparam int A = 4;
  localparam int D = 16;

  logic clk;
  logic rst;

  int checks;
  int failures;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] ref_q[$];

  psum_scratch_buffer_if #(.SCRATCH_WIDTH(W), .ADDR_LEN(A)) bus ();

  psum_scratch_buffer #(
    .SCRATCH_DEPTH(D),
    .SCRATCH_WIDTH(W),
    .ADDR_LEN     (A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read scoreboard: every rvalid pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst && bus.rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rvalid_unexpected: rvalid=1 rdata=%h, required no read", bus.rdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.rdata !== e) begin
          failures++;
          $display("FAIL rdata: got %h required %h", bus.rdata, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic set_idle();
    bus.psum_clear     = 1'b0;
    bus.wen            = 1'b0;
    bus.wdata          = '0;
    bus.accumulate     = 1'b0;
    bus.psum_ren       = 1'b0;
    bus.psum_same_addr = 1'b0;
  endtask

  // One clock of stimulus; returns #1 after the edge with inputs idle.
  task automatic step(input logic w, input logic acc, input logic [W-1:0] d,
                      input logic r, input logic same, input logic clr);
    bus.wen            = w;
    bus.accumulate     = acc;
    bus.wdata          = d;
    bus.psum_ren       = r;
    bus.psum_same_addr = same;
    bus.psum_clear     = clr;
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic push(input logic [W-1:0] d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input logic [W-1:0] e);
    exp_q.push_back(e);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.psum_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b required 1", bus.psum_empty); end
    checks++; if (bus.psum_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b required 0", bus.psum_full); end
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d required 0", bus.count); end
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b required 0", bus.rvalid); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b required 0", bus.overflow); end
    checks++; if (bus.rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata: got %h required 0", bus.rdata); end
    rst = 1'b0;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.psum_empty !== 1'b1) begin failures++; $display("FAIL idle_empty: got %b required 1", bus.psum_empty); end
  endtask

  task automatic test_fifo_order();
    push(16'd5);
    push(16'd7);
    push(16'd9);
    checks++; if (bus.count !== 5'd3) begin failures++; $display("FAIL fifo_count3: got %0d required 3", bus.count); end
    pop(16'd5);
    checks++; if (bus.psum_done !== 1'b0) begin failures++; $display("FAIL fifo_done_early1: got %b required 0", bus.psum_done); end
    pop(16'd7);
    checks++; if (bus.psum_done !== 1'b0) begin failures++; $display("FAIL fifo_done_early2: got %b required 0", bus.psum_done); end
    pop(16'd9);
    checks++; if (bus.psum_done !== 1'b1) begin failures++; $display("FAIL fifo_done: got %b required 1", bus.psum_done); end
    checks++; if (bus.psum_empty !== 1'b1) begin failures++; $display("FAIL fifo_empty: got %b required 1", bus.psum_empty); end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.psum_done !== 1'b0) begin failures++; $display("FAIL fifo_done_pulse: got %b required 0", bus.psum_done); end
    // Read of an empty buffer is ignored.
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL empty_read_rvalid: got %b required 0", bus.rvalid); end
  endtask

  task automatic test_accumulate();
    push(16'd10);
    step(1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'd12);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.count !== 5'd1) begin failures++; $display("FAIL acc_count: got %0d required 1", bus.count); end
    step(1'b1, 1'b1, 16'hFFF5, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'h0001);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    pop(16'h0001);
    checks++; if (bus.psum_empty !== 1'b1) begin failures++; $display("FAIL acc_empty: got %b required 1", bus.psum_empty); end
    // Accumulate into an empty buffer is a push.
    step(1'b1, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd1) begin failures++; $display("FAIL acc_empty_push: got %0d required 1", bus.count); end
    pop(16'h0042);
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < D; i++) push(W'(i));
    checks++; if (bus.psum_full !== 1'b1) begin failures++; $display("FAIL full_flag: got %b required 1", bus.psum_full); end
    checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL full_count: got %0d required 16", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL overflow_early: got %b required 0", bus.overflow); end
    push(16'd99);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL overflow: got %b required 1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL overflow_count: got %0d required 16", bus.count); end
    exp_q.push_back(16'd0);
    step(1'b1, 1'b0, 16'd100, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL full_poppush_count: got %0d required 16", bus.count); end
    for (int i = 1; i < D; i++) pop(W'(i));
    pop(16'd100);
    checks++; if (bus.psum_empty !== 1'b1) begin failures++; $display("FAIL full_drain_empty: got %b required 1", bus.psum_empty); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky: got %b required 1", bus.overflow); end
  endtask

  task automatic test_wrap();
    int pushed;
    int occ;
    logic do_push;
    logic do_pop;
    logic [W-1:0] d;
    pushed = 0;
    ref_q.delete();
    while (pushed < 40 || ref_q.size() > 0) begin
      occ = ref_q.size();
      do_push = 1'b0;
      do_pop  = 1'b0;
      if (pushed >= 40) begin
        do_pop = 1'b1;
      end else if (occ == 0) begin
        do_push = 1'b1;
      end else if (occ >= 3) begin
        do_pop  = 1'b1;
        do_push = 1'($urandom_range(0, 1));
      end else begin
        case ($urandom_range(0, 2))
          0: do_push = 1'b1;
          1: begin do_push = 1'b1; do_pop = 1'b1; end
          default: begin
            do_pop = (occ > 1);
            do_push = (occ == 1);
          end
        endcase
      end
      d = W'($urandom_range(0, 65535));
      if (do_pop) exp_q.push_back(ref_q.pop_front());
      if (do_push) begin
        ref_q.push_back(d);
        pushed++;
      end
      step(do_push, 1'b0, d, do_pop, 1'b0, 1'b0);
      checks++;
      if (bus.count !== 5'(ref_q.size())) begin
        failures++;
        $display("FAIL wrap_count: got %0d required %0d", bus.count, ref_q.size());
      end
    end
  endtask

  task automatic test_pop_accumulate();
    push(16'd4);
    exp_q.push_back(16'd4);
    step(1'b1, 1'b1, 16'd6, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.count !== 5'd1) begin failures++; $display("FAIL popacc_count: got %0d required 1", bus.count); end
    checks++; if (bus.psum_done !== 1'b0) begin failures++; $display("FAIL popacc_done_early: got %b required 0", bus.psum_done); end
    pop(16'd6);
    checks++; if (bus.psum_done !== 1'b1) begin failures++; $display("FAIL popacc_done: got %b required 1", bus.psum_done); end
  endtask

  task automatic test_clear();
    push(16'd1);
    push(16'd2);
    push(16'd3);
    step(1'b1, 1'b0, 16'd77, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL clear_count: got %0d required 0", bus.count); end
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL clear_rvalid: got %b required 0", bus.rvalid); end
    checks++; if (bus.psum_done !== 1'b0) begin failures++; $display("FAIL clear_done: got %b required 0", bus.psum_done); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL clear_overflow: got %b required 0", bus.overflow); end
    checks++; if (bus.psum_empty !== 1'b1) begin failures++; $display("FAIL clear_empty: got %b required 1", bus.psum_empty); end
    push(16'd8);
    pop(16'd8);
  endtask

  task automatic test_async_reset();
    push(16'h0055);
    pop(16'h0055);
    push(16'd1);
    push(16'd2);
    bus.wen   = 1'b1;
    bus.wdata = 16'd3;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL areset_count: got %0d required 0", bus.count); end
    checks++; if (bus.psum_empty !== 1'b1) begin failures++; $display("FAIL areset_empty: got %b required 1", bus.psum_empty); end
    checks++; if (bus.rdata !== 16'h0) begin failures++; $display("FAIL areset_rdata: got %h required 0", bus.rdata); end
    checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL areset_rvalid: got %b required 0", bus.rvalid); end
    checks++; if (bus.psum_done !== 1'b0) begin failures++; $display("FAIL areset_done: got %b required 0", bus.psum_done); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_idle();
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL areset_hold: got %0d required 0", bus.count); end
    push(16'd21);
    pop(16'd21);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fifo_order();
    test_accumulate();
    test_full_overflow();
    test_wrap();
    test_pop_accumulate();
    test_clear();
    test_async_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reads_missing: got %0d outstanding required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_scratch_buffer.md
Name: psum_scratch_buffer

Overview:
- Partial-sum scratchpad that answers the psum request lines driven by the design controller: psum_clear, psum_ren, psum_same_addr and accumulate.
- Stores PE partial sums in a circular FIFO of SCRATCH_DEPTH x SCRATCH_WIDTH entries.
- Supports in-place accumulation onto the newest entry, and both peek and pop reads.
- Returns psum_empty, psum_full and psum_done status to the controller.

Parameters:
SCRATCH_DEPTH, 16, number of entries; must be a power of two, at least 2
SCRATCH_WIDTH, 16, bits per partial sum
ADDR_LEN, 4, pointer width; equals log2(SCRATCH_DEPTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
psum_clear  input  1  synchronous flush of the buffer
wen  input  1  write strobe from the PE
wdata  input  SCRATCH_WIDTH  partial sum to store or add
accumulate  input  1  with wen: add wdata into the newest entry instead of pushing
psum_ren  input  1  read request
psum_same_addr  input  1  with psum_ren: 1 = peek (head kept), 0 = pop (head advances)
rdata  output  SCRATCH_WIDTH  registered read data
rvalid  output  1  one-cycle pulse, rdata valid
psum_empty  output  1  count == 0
psum_full  output  1  count == SCRATCH_DEPTH
psum_done  output  1  one-cycle pulse: buffer drained by a pop
count  output  ADDR_LEN+1  current occupancy
overflow  output  1  sticky: a push was dropped while full

Behaviour:
- Reset (rst high, asynchronous) sets:
  - rd_ptr = 0, wr_ptr = 0, count = 0
  - rdata = 0, rvalid = 0, psum_done = 0, overflow = 0
  - psum_empty = 1, psum_full = 0
  - Memory contents are don't-care.
- Priority, every rising edge: rst > psum_clear > normal operation.
- psum_clear: pointers, count, rvalid, psum_done and overflow go to 0 on the next edge. All wen/ren in that same cycle are ignored. Memory is not zeroed.
- Status flags psum_empty, psum_full and count are combinational from the registered count. They change the cycle after the causing edge.
- Push (wen=1, accumulate=0):
  - If not full: mem[wr_ptr] <= wdata, wr_ptr increments (wraps modulo SCRATCH_DEPTH), count increments.
  - If full and no pop this cycle: the write is dropped, overflow <= 1, pointers unchanged.
  - If full with a simultaneous pop: the push is accepted.
- Accumulate (wen=1, accumulate=1):
  - If count > 0: mem[wr_ptr-1] <= mem[wr_ptr-1] + wdata, truncated to SCRATCH_WIDTH (two's-complement wrap). wr_ptr and count are unchanged.
  - If count == 0: behaves exactly as a push.
  - If count == 1 and a pop is issued the same cycle, the target entry leaves, so the accumulate becomes a push of wdata. Net count stays 1.
- Read (psum_ren=1):
  - If count > 0: rdata <= mem[rd_ptr] at the edge, and rvalid = 1 for the following cycle. Read latency is 1 cycle.
  - Peek (psum_same_addr=1): rd_ptr is unchanged.
  - Pop (psum_same_addr=0): rd_ptr increments (wraps) and count decrements.
  - If count == 0: ignored; rvalid = 0 and rdata holds its value.
  - rdata holds its last value whenever rvalid = 0.
- Simultaneous events:
  - Pop + push: both occur and count is unchanged.
  - Read + accumulate to the same entry: the read returns the pre-add value.
  - Push when count == 0 with a read the same cycle: the read is ignored, because it sees the registered empty state.
- psum_done: pulses 1 for one cycle after an edge where a pop took count from 1 to 0 with no accepted push. It does not pulse on psum_clear or rst.
- Occupancy invariant: count never exceeds SCRATCH_DEPTH and never goes negative. Pointer wrap is transparent.
- Reset asserted mid-operation aborts everything immediately. There is no partial state.

Test Plan:
1. Reset then idle: psum_empty=1, count=0, rvalid=0, overflow=0. Push 5, 7, 9, then pop three times with same_addr=0 → rdata 5, 7, 9 on consecutive rvalid cycles. psum_done pulses once after the third pop; psum_empty=1.
2. Push 10, then accumulate 3 and accumulate -1 (0xFFFF) → peek returns 12 with count=1. Then accumulate 0xFFF5 onto 12 → 0x0001 (wrap-around).
3. Fill 16 entries (0..15) → psum_full=1. A 17th push is dropped and overflow=1. Pop+push in the same cycle while full → count stays 16; the popped value is 0 and the new entry appears last.
4. Wrap: push/pop 40 values with occupancy kept between 1 and 3 → output order matches input order across pointer wrap; count is correct each cycle.
5. count=1 (value 4); pop + accumulate 6 in the same cycle → rdata=4, count stays 1, next pop returns 6, and psum_done pulses only after that second pop.
6. Load 3 entries, assert psum_clear together with wen and ren → count=0, no rvalid, no psum_done. Assert rst asynchronously mid-burst → all outputs reach reset values before the next clock edge.
